// File: rtl/comparador_mayor_igualdad.sv
// Registered magnitude comparator: flags A > B, A == B, A < B one cycle after
// in_valid, with out_valid marking fresh results. Flags hold while idle.
module comparador_mayor_igualdad #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             F_mayor,
  output logic             F_igual,
  output logic             F_menor,
  output logic             out_valid
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic             eq_prefix;
  logic             gt;
  logic             eq;
  logic             lt;

  // Greater-than cascade from the MSB down; the first differing bit decides.
  // In signed mode the sign bits are inverted so negatives rank below
  // non-negatives, and the remaining bits compare as unsigned.
  always_comb begin
    a_m       = A;
    b_m       = B;
    if (SIGNED) begin
      a_m[WIDTH-1] = ~A[WIDTH-1];
      b_m[WIDTH-1] = ~B[WIDTH-1];
    end
    eq_prefix = 1'b1;
    gt        = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      gt        = gt | (eq_prefix & a_m[i] & ~b_m[i]);
      eq_prefix = eq_prefix & ~(a_m[i] ^ b_m[i]);
    end
  end

  // Equality by XNOR-reduce; less-than is whatever is neither greater nor equal.
  always_comb begin
    eq = &(A ~^ B);
    lt = ~gt & ~eq;
  end

  // Result registers: reset wins, flags load only on in_valid, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_mayor   <= 1'b0;
      F_igual   <= 1'b0;
      F_menor   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        F_mayor <= gt;
        F_igual <= eq;
        F_menor <= lt;
      end
    end
  end

endmodule

// File: tb/tb_comparador_mayor_igualdad.sv
// Self-checking bench: an unsigned and a signed 4-bit comparator share the
// same stimulus and are compared against an integer-arithmetic reference.
module tb_comparador_mayor_igualdad;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic       u_mayor, u_igual, u_menor, u_valid;
  logic       s_mayor, s_igual, s_menor, s_valid;

  int total;
  int bad;

  // Reference state of the registered outputs.
  logic [2:0] exp_u;
  logic [2:0] exp_s;
  logic       exp_valid;

  comparador_mayor_igualdad #(
    .WIDTH (4),
    .SIGNED(1'b0)
  ) dut_u (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .in_valid (in_valid),
    .F_mayor  (u_mayor),
    .F_igual  (u_igual),
    .F_menor  (u_menor),
    .out_valid(u_valid)
  );

  comparador_mayor_igualdad #(
    .WIDTH (4),
    .SIGNED(1'b1)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .in_valid (in_valid),
    .F_mayor  (s_mayor),
    .F_igual  (s_igual),
    .F_menor  (s_menor),
    .out_valid(s_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Operand value as a plain integer, sign-interpreted when requested.
  function automatic int value_of(input logic [3:0] x, input bit sgn);
    int v;
    v = int'(x);
    if (sgn && v >= 8) v = v - 16;
    return v;
  endfunction

  // Expected {greater, equal, less}.
  function automatic logic [2:0] ref_flags(input logic [3:0] x, input logic [3:0] y,
                                           input bit sgn);
    int vx;
    int vy;
    vx = value_of(x, sgn);
    vy = value_of(y, sgn);
    return {vx > vy, vx == vy, vx < vy};
  endfunction

  // Apply one cycle of stimulus, advance the reference, then check after the edge.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [3:0] x, input logic [3:0] y);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    if (r) begin
      exp_u     = 3'b000;
      exp_s     = 3'b000;
      exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_u = ref_flags(x, y, 1'b0);
        exp_s = ref_flags(x, y, 1'b1);
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_u"}, {28'd0, u_valid, u_mayor, u_igual, u_menor}, {28'd0, exp_valid, exp_u});
    check({tag, "_s"}, {28'd0, s_valid, s_mayor, s_igual, s_menor}, {28'd0, exp_valid, exp_s});
    if (exp_valid) begin
      check({tag, "_onehot_u"}, 32'($countones({u_mayor, u_igual, u_menor})), 32'd1);
      check({tag, "_onehot_s"}, 32'($countones({s_mayor, s_igual, s_menor})), 32'd1);
    end
  endtask

  // One valid sample followed by idle cycles holding the same operands.
  task automatic pulse(input string tag, input logic [3:0] x, input logic [3:0] y);
    cycle(tag, 1'b0, 1'b1, x, y);
    for (int k = 0; k < 4; k++) cycle({tag, "_idle"}, 1'b0, 1'b0, x, y);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_u     = 3'b000;
    exp_s     = 3'b000;
    exp_valid = 1'b0;

    // Reset with a valid equal pair present: everything must read 0.
    cycle("reset0", 1'b1, 1'b1, 4'd7, 4'd7);
    cycle("reset1", 1'b1, 1'b1, 4'd7, 4'd7);

    // Unsigned sequence, one pulse every 5 cycles.
    pulse("lt_3_8", 4'd3, 4'd8);
    pulse("gt_3_1", 4'd3, 4'd1);
    pulse("eq_7_7", 4'd7, 4'd7);
    pulse("eq_8_8", 4'd8, 4'd8);

    // Hold: flags keep A>B while in_valid is low and A changes.
    cycle("hold_ld", 1'b0, 1'b1, 4'd3, 4'd1);
    cycle("hold_a0", 1'b0, 1'b0, 4'd0, 4'd1);
    cycle("hold_a0b", 1'b0, 1'b0, 4'd0, 4'd1);

    // Signed-sensitive pairs and extremes.
    pulse("sgn_3_m8", 4'b0011, 4'b1000);
    pulse("sgn_m1_0", 4'b1111, 4'b0000);
    pulse("ext_15_0", 4'd15, 4'd0);
    pulse("ext_0_15", 4'd0, 4'd15);
    pulse("ext_15_15", 4'd15, 4'd15);
    pulse("ext_0_0", 4'd0, 4'd0);
    pulse("sgn_m8_7", 4'b1000, 4'b0111);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        cycle("sweep", 1'b0, 1'b1, 4'(i), 4'(j));
      end
    end

    // Reset mid-stream discards the operand sampled at that edge.
    cycle("pre_rst", 1'b0, 1'b1, 4'd9, 4'd2);
    cycle("mid_rst", 1'b1, 1'b1, 4'd2, 4'd9);
    cycle("post_rst", 1'b0, 1'b0, 4'd2, 4'd9);
    cycle("first_v", 1'b0, 1'b1, 4'd2, 4'd9);

    // Random traffic with sporadic idle cycles and resets.
    for (int n = 0; n < 300; n++) begin
      cycle("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
